// File: rtl/k_seq_alu.sv
// k_seq_alu: clocked add/sub/iterative mul/div unit with start/busy/done handshake; divide built only when K_SEQ_ALU_DIV_EN is defined
module k_seq_alu #(
  parameter int WIDTH = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [WIDTH-1:0]     r1,
  input  logic [WIDTH-1:0]     r2,
  input  logic [1:0]           switch,
  output logic [2*WIDTH-1:0]   r3,
  output logic                 cout,
  output logic                 err,
  output logic                 busy,
  output logic                 done
);
  localparam int CW = $clog2(WIDTH + 1);
  typedef enum logic {IDLE, RUN} state_t;
  state_t state;
  logic [CW-1:0] cnt;
  logic [2*WIDTH-1:0] acc, nxt;
  logic [WIDTH-1:0] b;
  logic [WIDTH:0] sum, dif, msum;
`ifdef K_SEQ_ALU_DIV_EN
  logic op_div;
  logic [WIDTH:0] t, d;
`endif
  // acc holds {high partial, low operand}: multiplier bits shift out LSB first, quotient bits shift in at the LSB
  always_comb begin
    sum = {1'b0, r1} + {1'b0, r2};
    dif = {1'b0, r1} - {1'b0, r2};
    msum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, b} : '0);
`ifdef K_SEQ_ALU_DIV_EN
    t = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    d = t - {1'b0, b};
    nxt = !op_div ? {msum, acc[WIDTH-1:1]}
        : d[WIDTH] ? {t[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
        : {d[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
`else
    nxt = {msum, acc[WIDTH-1:1]};
`endif
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt <= '0;
      acc <= '0;
      b <= '0;
      r3 <= '0;
      cout <= 1'b0;
      err <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
`ifdef K_SEQ_ALU_DIV_EN
      op_div <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      if (state == IDLE) begin
        if (start) begin
          case (switch)
            2'b00: begin
              r3 <= {{(WIDTH-1){1'b0}}, sum};
              cout <= sum[WIDTH];
              err <= 1'b0;
              done <= 1'b1;
            end
            2'b01: begin
              r3 <= {{WIDTH{1'b0}}, dif[WIDTH-1:0]};
              cout <= dif[WIDTH];
              err <= 1'b0;
              done <= 1'b1;
            end
            2'b10: begin
              acc <= {{WIDTH{1'b0}}, r1};
              b <= r2;
              cnt <= CW'(WIDTH);
              busy <= 1'b1;
              state <= RUN;
`ifdef K_SEQ_ALU_DIV_EN
              op_div <= 1'b0;
`endif
            end
            default: begin
`ifdef K_SEQ_ALU_DIV_EN
              if (r2 == '0) begin
                r3 <= {r1, {WIDTH{1'b1}}};
                cout <= 1'b0;
                err <= 1'b1;
                done <= 1'b1;
              end else begin
                acc <= {{WIDTH{1'b0}}, r1};
                b <= r2;
                cnt <= CW'(WIDTH);
                busy <= 1'b1;
                state <= RUN;
                op_div <= 1'b1;
              end
`else
              r3 <= '0;
              cout <= 1'b0;
              err <= 1'b1;
              done <= 1'b1;
`endif
            end
          endcase
        end
      end else begin
        acc <= nxt;
        cnt <= cnt - 1'b1;
        if (cnt == CW'(1)) begin
          r3 <= nxt;
          cout <= 1'b0;
          err <= 1'b0;
          done <= 1'b1;
          busy <= 1'b0;
          state <= IDLE;
        end
      end
    end
  end
endmodule

// File: tb/tb_k_seq_alu.sv
// tb_k_seq_alu: directed self-checking bench for k_seq_alu (WIDTH=4 and WIDTH=8 instances)
module tb_k_seq_alu;
  logic clk = 0, reset = 1, start = 0;
  logic [3:0] r1 = 0, r2 = 0;
  logic [1:0] switch = 0;
  logic [7:0] r3;
  logic cout, err, busy, done;
  logic start8 = 0;
  logic [7:0] a8 = 0, b8 = 0;
  logic [1:0] sw8 = 0;
  logic [15:0] r3_8;
  logic cout8, err8, busy8, done8;
  int pass = 0, total = 0;

  k_seq_alu #(.WIDTH(4)) dut (.clk(clk), .reset(reset), .start(start), .r1(r1), .r2(r2),
    .switch(switch), .r3(r3), .cout(cout), .err(err), .busy(busy), .done(done));
  k_seq_alu #(.WIDTH(8)) dut8 (.clk(clk), .reset(reset), .start(start8), .r1(a8), .r2(b8),
    .switch(sw8), .r3(r3_8), .cout(cout8), .err(err8), .busy(busy8), .done(done8));

  always #5 clk = ~clk;

  task automatic go(input logic [1:0] sw, input logic [3:0] a, input logic [3:0] bb);
    switch = sw; r1 = a; r2 = bb; start = 1;
    @(posedge clk); #1;
    start = 0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
    end
  endtask

  task automatic test_reset;
    reset = 1;
    repeat (2) @(posedge clk);
    #1;
    total++; if ({r3, cout, err, busy, done} !== 12'h0) $display("FAIL reset4 got %h want 0", {r3, cout, err, busy, done}); else pass++;
    total++; if ({r3_8, cout8, err8, busy8, done8} !== 20'h0) $display("FAIL reset8 got %h want 0", {r3_8, cout8, err8, busy8, done8}); else pass++;
    reset = 0;
  endtask

  task automatic test_add;
    go(2'b00, 4'd9, 4'd8);
    total++; if ({r3, cout, done, busy} !== {8'h11, 3'b110}) $display("FAIL add got r3=%h c=%b d=%b b=%b want 11 1 1 0", r3, cout, done, busy); else pass++;
    @(posedge clk); #1;
    total++; if ({r3, done} !== {8'h11, 1'b0}) $display("FAIL add_hold got r3=%h d=%b want 11 0", r3, done); else pass++;
  endtask

  task automatic test_back_to_back;
    go(2'b01, 4'd3, 4'd5);
    total++; if ({r3, cout, done} !== {8'h0E, 2'b11}) $display("FAIL sub35 got r3=%h c=%b d=%b want 0e 1 1", r3, cout, done); else pass++;
    go(2'b01, 4'd5, 4'd3);
    total++; if ({r3, cout, done} !== {8'h02, 2'b01}) $display("FAIL sub53 got r3=%h c=%b d=%b want 02 0 1", r3, cout, done); else pass++;
  endtask

  task automatic test_mul;
    int first = 0, dcount = 0;
    go(2'b10, 4'd15, 4'd15);
    total++; if ({r3, busy, done} !== {8'h02, 2'b10}) $display("FAIL mul_e0 got r3=%h b=%b d=%b want 02 1 0", r3, busy, done); else pass++;
    for (int i = 1; i <= 8; i++) begin
      if (i == 1) begin switch = 2'b00; r1 = 4'd1; r2 = 4'd1; start = 1; end
      if (i == 2) start = 0;
      @(posedge clk); #1;
      if (i == 2) begin
        total++; if (busy !== 1'b1) $display("FAIL mul_busy got %b want 1", busy); else pass++;
      end
      if (done) begin dcount++; if (first == 0) first = i; end
    end
    start = 0;
    total++; if (first !== 4) $display("FAIL mul_lat got %0d want 4", first); else pass++;
    total++; if (dcount !== 1) $display("FAIL mul_ndone got %0d want 1", dcount); else pass++;
    total++; if ({r3, cout, err, busy} !== {8'hE1, 3'b000}) $display("FAIL mul15 got r3=%h c=%b e=%b b=%b want e1 0 0 0", r3, cout, err, busy); else pass++;
  endtask

  task automatic test_div;
`ifdef K_SEQ_ALU_DIV_EN
    int lat;
    go(2'b11, 4'd13, 4'd4);
    total++; if ({busy, done} !== 2'b10) $display("FAIL div_e0 got b=%b d=%b want 1 0", busy, done); else pass++;
    wait_done(lat);
    total++; if (lat !== 4) $display("FAIL div_lat got %0d want 4", lat); else pass++;
    total++; if ({r3, err} !== {8'h13, 1'b0}) $display("FAIL div13_4 got r3=%h e=%b want 13 0", r3, err); else pass++;
    go(2'b11, 4'd7, 4'd0);
    total++; if ({r3, err, done, busy} !== {8'h7F, 3'b110}) $display("FAIL div0 got r3=%h e=%b d=%b b=%b want 7f 1 1 0", r3, err, done, busy); else pass++;
`else
    go(2'b11, 4'd13, 4'd4);
    total++; if ({r3, cout, err, done, busy} !== {8'h00, 4'b0110}) $display("FAIL div_off got r3=%h c=%b e=%b d=%b b=%b want 00 0 1 1 0", r3, cout, err, done, busy); else pass++;
`endif
  endtask

  task automatic test_reset_mid;
    int lat, dcount = 0;
    go(2'b10, 4'd6, 4'd7);
    @(posedge clk); #1;
    reset = 1;
    @(posedge clk); #1;
    total++; if ({r3, busy, done, err} !== 11'h0) $display("FAIL rst_mid got r3=%h b=%b d=%b e=%b want 0", r3, busy, done, err); else pass++;
    reset = 0;
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    total++; if ({dcount, busy} !== {32'd0, 1'b0}) $display("FAIL rst_nodone got dones=%0d b=%b want 0 0", dcount, busy); else pass++;
    go(2'b10, 4'd6, 4'd7);
    wait_done(lat);
    total++; if (lat !== 4) $display("FAIL mul67_lat got %0d want 4", lat); else pass++;
    total++; if (r3 !== 8'h2A) $display("FAIL mul67 got %h want 2a", r3); else pass++;
  endtask

  task automatic test_wide;
    int lat = 0;
    sw8 = 2'b10; a8 = 8'd255; b8 = 8'd255; start8 = 1;
    @(posedge clk); #1;
    start8 = 0; a8 = 0; b8 = 0;
    total++; if ({busy8, done8} !== 2'b10) $display("FAIL w_e0 got b=%b d=%b want 1 0", busy8, done8); else pass++;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done8) begin lat = i; break; end
    end
    total++; if (lat !== 8) $display("FAIL w_lat got %0d want 8", lat); else pass++;
    total++; if ({r3_8, busy8} !== {16'hFE01, 1'b0}) $display("FAIL w_mul got %h b=%b want fe01 0", r3_8, busy8); else pass++;
  endtask

  initial begin
    test_reset;
    test_add;
    test_back_to_back;
    test_mul;
    test_div;
    test_reset_mid;
    test_wide;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule
